// File: rtl/vga_scan.sv
// vga_scan: 640x480@60 raster timing master with px-aligned hs/vs/rgb.
// Ports: clk, RESET_N (async low), px in; row_addr/col_addr/fresh to renderers;
// hs, vs, r, g, b to the connector. Optional VGA_TESTPAT_EN adds testpat input.
module vga_scan #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter int          PX_LAT   = 1,
  parameter logic [11:0] FG_COLOR = 12'h555,
  parameter logic [11:0] BG_COLOR = 12'hFFF
) (
  input  logic       clk,
  input  logic       RESET_N,
`ifdef VGA_TESTPAT_EN
  input  logic       testpat,
`endif
  input  logic       px,
  output logic [8:0] row_addr,
  output logic [9:0] col_addr,
  output logic       fresh,
  output logic       hs,
  output logic       vs,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b
);

  localparam logic [9:0] H_MAX  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_MAX  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [8:0] ROW_LAST = 9'(V_ACTIVE - 1);

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
`ifdef VGA_TESTPAT_EN
    logic [2:0] bar;
`endif
  } pipe_t;

`ifdef VGA_TESTPAT_EN
  localparam pipe_t PIPE_RST = '{hs: 1'b1, vs: 1'b1, act: 1'b0, bar: 3'd0};
`else
  localparam pipe_t PIPE_RST = '{hs: 1'b1, vs: 1'b1, act: 1'b0};
`endif

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic [8:0] row_q, row_d;
  logic       fresh_q, fresh_d;
  logic       hs_q, vs_q;
  logic [11:0] rgb_q, rgb_d;

  pipe_t              raw;
  pipe_t              tail;
  pipe_t [PX_LAT-1:0] pipe_q;

  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_MAX) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_MAX) ? '0 : v_cnt_q + 10'd1;
    end
    fresh_d = (v_cnt_d < V_ACT);
    // row holds on the last visible line through vblank
    row_d   = fresh_d ? v_cnt_d[8:0] : ROW_LAST;
  end

  always_comb begin
    raw     = PIPE_RST;
    raw.hs  = !((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END));
    raw.vs  = !((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END));
    raw.act = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
`ifdef VGA_TESTPAT_EN
    raw.bar = h_cnt_q[9:7];
`endif
  end

  assign tail = pipe_q[PX_LAT-1];

  // blanking forces black so a floating px never reaches the pins
  always_comb begin
    rgb_d = '0;
    if (tail.act) begin
      rgb_d = px ? FG_COLOR : BG_COLOR;
`ifdef VGA_TESTPAT_EN
      if (testpat)
        rgb_d = {{4{tail.bar[2]}}, {4{tail.bar[1]}}, {4{tail.bar[0]}}};
`endif
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      row_q   <= '0;
      fresh_q <= 1'b1;
      pipe_q  <= {PX_LAT{PIPE_RST}};
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      rgb_q   <= '0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      row_q     <= row_d;
      fresh_q   <= fresh_d;
      pipe_q[0] <= raw;
      for (int i = 1; i < PX_LAT; i++)
        pipe_q[i] <= pipe_q[i-1];
      hs_q  <= tail.hs;
      vs_q  <= tail.vs;
      rgb_q <= rgb_d;
    end
  end

  assign col_addr = h_cnt_q;
  assign row_addr = row_q;
  assign fresh    = fresh_q;
  assign hs       = hs_q;
  assign vs       = vs_q;
  assign r        = rgb_q[11:8];
  assign g        = rgb_q[7:4];
  assign b        = rgb_q[3:0];

endmodule

// File: tb/tb_vga_scan.sv
// tb_vga_scan: scoreboard bench for vga_scan with a shortened vertical frame.
// Horizontal timing is the real 800-clock line; vertical uses 23 lines.
module tb_vga_scan;

  localparam int VA = 16;
  localparam int VF = 2;
  localparam int VSY = 2;
  localparam int VB = 3;
  localparam int VT = VA + VF + VSY + VB;

  logic       clk = 1'b0;
  logic       RESET_N = 1'b0;
  logic       px = 1'b0;
  logic [8:0] row_addr;
  logic [9:0] col_addr;
  logic       fresh, hs, vs;
  logic [3:0] r, g, b;

  vga_scan #(
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)
  ) dut (
    .clk(clk),
    .RESET_N(RESET_N),
`ifdef VGA_TESTPAT_EN
    .testpat(1'b0),
`endif
    .px(px),
    .row_addr(row_addr),
    .col_addr(col_addr),
    .fresh(fresh),
    .hs(hs),
    .vs(vs),
    .r(r),
    .g(g),
    .b(b)
  );

  always #20 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } out_t;

  out_t sb[$];
  out_t e;
  int   h_m, v_m;
  int   mode = 0;
  int   prev_col = -1;
  int   prev_v = 0;
  int   hs_run = 0;
  int   vs_run = 0;
  int   rexp;
  logic [9:0] hexp;
  logic [8:0] rexp9;

  always @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      h_m <= 0;
      v_m <= 0;
    end else if (h_m == 799) begin
      h_m <= 0;
      v_m <= (v_m == VT - 1) ? 0 : v_m + 1;
    end else begin
      h_m <= h_m + 1;
    end
  end

  function automatic logic in_win(int c);
    return (c >= 120) && (c < 153);
  endfunction

  function automatic out_t pix_exp(int h, int v, int md);
    out_t o;
    logic pv;
    pv    = (md == 1) ? 1'b1 : in_win(h);
    o.hs  = !((h >= 656) && (h < 752));
    o.vs  = !((v >= VA + VF) && (v < VA + VF + VSY));
    o.rgb = 12'h000;
    if ((h < 640) && (v < VA))
      o.rgb = pv ? 12'h555 : 12'hFFF;
    return o;
  endfunction

  always @(negedge clk) begin
    if (!RESET_N) begin
      sb.delete();
      hs_run = 0;
      vs_run = 0;
      prev_col = -1;
      chk("rst_out", {hs, vs, r, g, b, fresh}, {1'b1, 1'b1, 12'h000, 1'b1});
      chk("rst_addr", {col_addr, row_addr}, 0);
    end else begin
      // renderer model: one-clock registered response to the address
      if (prev_col < 0)
        px = 1'b0;
      else if (prev_col >= 640 || prev_v >= VA)
        px = 1'($urandom_range(1));
      else
        px = (mode == 1) ? 1'b1 : in_win(prev_col);
      prev_col = int'(col_addr);
      prev_v   = v_m;

      hexp  = h_m[9:0];
      rexp  = (v_m < VA) ? v_m : VA - 1;
      rexp9 = rexp[8:0];
      chk("addr", {col_addr, row_addr, fresh}, {hexp, rexp9, v_m < VA});

      sb.push_back(pix_exp(h_m, v_m, mode));
      if (sb.size() == 3) begin
        e = sb.pop_front();
        chk("pix", {hs, vs, r, g, b}, e);
      end

      if (!hs) hs_run++;
      else begin
        if (hs_run != 0) chk("hs_width", hs_run, 96);
        hs_run = 0;
      end
      if (!vs) vs_run++;
      else begin
        if (vs_run != 0) chk("vs_width", vs_run, VSY * 800);
        vs_run = 0;
      end
    end
  end

  int n;
  int guard;

  initial begin
    RESET_N = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #5 RESET_N = 1'b1;

    repeat (VT * 800) @(negedge clk);
    guard = 0;
    while (v_m != VA + 1 && guard < VT * 800) begin
      @(negedge clk);
      guard++;
    end
    chk("reach_vblank", v_m, VA + 1);
    #1 mode = 1;

    repeat (VT * 800) @(negedge clk);
    guard = 0;
    while (!(v_m == 10 && col_addr == 10'd300) && guard < VT * 800) begin
      @(negedge clk);
      guard++;
    end
    chk("reach_l10c300", {v_m[15:0], 6'd0, col_addr}, {16'd10, 6'd0, 10'd300});

    #5 RESET_N = 1'b0;
    #1;
    chk("mid_rst_out", {hs, vs, r, g, b, fresh}, {1'b1, 1'b1, 12'h000, 1'b1});
    chk("mid_rst_addr", {col_addr, row_addr}, 0);
    @(negedge clk);
    #5 RESET_N = 1'b1;

    n = 0;
    while (hs && n < 2000) begin
      @(posedge clk);
      #1 n++;
    end
    chk("hs_after_rst", n, 658);

    repeat (1700) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
